fifo_async_wr_arb: RTL

FIFO_ASYNC_WR_ARB -- requirements
Module: fifo_async_wr_arb

---
 rtl/fifo_async_wr_arb.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fifo_async_wr_arb.sv
// Round-robin arbiter that multiplexes NumReq write-domain requesters onto
// the single write port of an async FIFO. A requester holds the port for a
// whole burst (until its last beat) or until MaxBurst beats, whichever
// comes first; a forced release raises a one-cycle burst_err_o pulse.
//
// Handshake: a beat moves on the FIFO port in any cycle where
// fifo_wvalid_o && fifo_wready_i. The granted requester sees that same
// acceptance as req_ready_o[gnt]. Valid may not depend on ready. Every
// non-granted requester sees ready low.
module fifo_async_wr_arb #(
  parameter int NumReq   = 4,
  parameter int Width    = 16,
  parameter int Depth    = 3,
  parameter int MaxBurst = 8,
  parameter int MinFree  = 1,
  localparam int DepthW  = $clog2(Depth + 1),
  localparam int IdxW    = (NumReq > 1) ? $clog2(NumReq) : 1,
  localparam int CntW    = $clog2(MaxBurst + 1)
) (
  input  logic                    clk_wr_i,
  input  logic                    rst_wr_ni,
  input  logic [NumReq-1:0]       req_valid_i,
  input  logic [NumReq-1:0]       req_last_i,
  input  logic [NumReq*Width-1:0] req_data_i,
  output logic [NumReq-1:0]       req_ready_o,
  output logic                    fifo_wvalid_o,
  input  logic                    fifo_wready_i,
  output logic [IdxW+Width-1:0]   fifo_wdata_o,
  input  logic [DepthW-1:0]       fifo_wdepth_i,
  output logic [IdxW-1:0]         gnt_idx_o,
  output logic                    busy_o,
  output logic                    burst_err_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]  gnt_q, gnt_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             burst_err_q, burst_err_d;

  logic [Width-1:0] data_arr [NumReq];
  logic             found;
  logic [IdxW-1:0]  win_idx;
  logic             free_ok;
  logic             beat_acc;
  logic [IdxW-1:0]  next_ptr;

  // (base + k) mod NumReq, kept at index width; works for non-power-of-2 NumReq.
  function automatic logic [IdxW-1:0] wrap_add(input logic [IdxW-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % NumReq;
    return s[IdxW-1:0];
  endfunction

  // Unpack the flat payload bus into one word per requester.
  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      data_arr[i] = req_data_i[i*Width +: Width];
    end
  end

  // Round-robin search: first valid requester starting at rr_ptr_q.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (!found && req_valid_i[wrap_add(rr_ptr_q, k)]) begin
        found   = 1'b1;
        win_idx = wrap_add(rr_ptr_q, k);
      end
    end
  end

  // Occupancy gate used only when a new grant would start.
  assign free_ok  = (Depth - int'(fifo_wdepth_i)) >= MinFree;
  assign beat_acc = fifo_wvalid_o && fifo_wready_i;
  assign next_ptr = wrap_add(gnt_q, 1);

  // Next-state and datapath outputs; IDLE drives everything to zero.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    gnt_d         = gnt_q;
    cnt_d         = cnt_q;
    burst_err_d   = 1'b0;
    fifo_wvalid_o = 1'b0;
    req_ready_o   = '0;
    fifo_wdata_o  = '0;
    case (state_q)
      IDLE: begin
        if (found && free_ok) begin
          state_d = LOCKED;
          gnt_d   = win_idx;
          cnt_d   = '0;
        end
      end
      LOCKED: begin
        fifo_wvalid_o      = req_valid_i[gnt_q];
        req_ready_o[gnt_q] = fifo_wready_i;
        fifo_wdata_o       = {gnt_q, data_arr[gnt_q]};
        if (beat_acc) begin
          cnt_d = cnt_q + CntW'(1);
          if (req_last_i[gnt_q]) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end else if (cnt_q == CntW'(MaxBurst - 1)) begin
            // Burst ran out of budget without a last beat: release the port.
            state_d     = IDLE;
            rr_ptr_d    = next_ptr;
            burst_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_wr_i or negedge rst_wr_ni) begin
    if (!rst_wr_ni) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      cnt_q       <= '0;
      burst_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      burst_err_q <= burst_err_d;
    end
  end

  assign gnt_idx_o   = gnt_q;
  assign busy_o      = (state_q == LOCKED);
  assign burst_err_o = burst_err_q;

endmodule
